// File: rtl/via_seq_arbiter.sv
// Sequencer arbiter: N requesters share one driver item channel with a single item in flight,
// round-robin or strict-priority selection, and lock/grab exclusivity.
module via_seq_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        req_done,
  output logic                    drv_valid,
  output logic [DATA_W-1:0]       drv_data,
  output logic [ID_W-1:0]         drv_id,
  input  logic                    drv_ready,
  input  logic                    drv_done,
  output logic                    locked,
  output logic [ID_W-1:0]         lock_owner,
  output logic [15:0]             issued_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ID_W-1:0]   gnt_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   lock_owner_r;
  logic [ID_W-1:0]   win_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] win_data_s;
  logic              lock_hold_r;
  logic              locked_r;
  logic              win_lock_s;
  logic              win_found_s;
  logic              take_s;
  logic [15:0]       issued_cnt_r;
  logic [N_REQ-1:0]  elig_s;
  logic [N_REQ-1:0]  gnt_onehot_s;
  int                rank_s;
  int                best_rank_s;

  // Eligible set and winner selection; rank 0 is the first candidate in the active scan order.
  always_comb begin
    elig_s      = locked_r ? (req_valid & (ONE_HOT_0 << lock_owner_r)) : req_valid;
    win_found_s = |elig_s;
    win_s       = '0;
    win_data_s  = '0;
    win_lock_s  = 1'b0;
    best_rank_s = N_REQ;
    rank_s      = 0;
    take_s      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      rank_s      = mode ? i : (i + N_REQ - 1 - int'(rr_ptr_r)) % N_REQ;
      take_s      = elig_s[i] && (rank_s < best_rank_s);
      best_rank_s = take_s ? rank_s : best_rank_s;
      win_s       = take_s ? ID_W'(i) : win_s;
      win_data_s  = take_s ? req_data[i*DATA_W +: DATA_W] : win_data_s;
      win_lock_s  = take_s ? req_lock[i] : win_lock_s;
    end
  end

  assign gnt_onehot_s = ONE_HOT_0 << gnt_r;

  // Next-state logic and the same-cycle accept/done pulses back to the granted requester.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    req_done    = '0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (drv_ready) begin
          state_nxt_s = WAIT_DONE;
          req_ready   = gnt_onehot_s;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (drv_done) begin
          state_nxt_s = IDLE;
          req_done    = gnt_onehot_s;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant capture: winner, payload and lock bit are held until done; the pointer follows the winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_r       <= '0;
      data_r      <= '0;
      lock_hold_r <= 1'b0;
      rr_ptr_r    <= ID_W'(N_REQ - 1);
    end else if (state_r == IDLE && win_found_s) begin
      gnt_r       <= win_s;
      data_r      <= win_data_s;
      lock_hold_r <= win_lock_s;
      rr_ptr_r    <= win_s;
    end
  end

  // Accept counter and lock ownership; an unlocking item from the owner releases on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_cnt_r <= 16'd0;
      locked_r     <= 1'b0;
      lock_owner_r <= '0;
    end else begin
      if (state_r == ISSUE && drv_ready) begin
        issued_cnt_r <= issued_cnt_r + 16'd1;
      end
      if (state_r == WAIT_DONE && drv_done) begin
        if (lock_hold_r) begin
          locked_r     <= 1'b1;
          lock_owner_r <= gnt_r;
        end else if (gnt_r == lock_owner_r) begin
          locked_r <= 1'b0;
        end
      end
    end
  end

  assign drv_valid  = (state_r == ISSUE);
  assign drv_data   = data_r;
  assign drv_id     = gnt_r;
  assign locked     = locked_r;
  assign lock_owner = lock_owner_r;
  assign issued_cnt = issued_cnt_r;

endmodule
